// File: rtl/addr_pkg.sv
// ---------------------------------------------------------------------------
// addr_pkg
// Shared definitions for the pipelined signed adder/subtractor (addr_signed_pipe).
//   RES_W        width of a mod-3 residue
//   chunk_width  carry-chain chunk width for a given operand width / stage count
//   res3         mod-3 residue of a signed value (always in 0..2)
//   res_combine  residue of (A +/- B) from the residues of A and B
// ---------------------------------------------------------------------------
package addr_pkg;

    localparam int RES_W = 2;

    // ceil((w+1)/s): the sum is one bit wider than the operands
    function automatic int chunk_width(input int w, input int s);
        return (w + s) / s;
    endfunction

    // Signed operands are widened to 65 bits by the caller so one function
    // covers every legal WIDTH. The % result carries the dividend's sign, so a
    // negative remainder is folded back into 0..2.
    function automatic logic [RES_W-1:0] res3(input logic signed [64:0] v);
        logic signed [64:0] m;
        m = v % 65'sd3;
        if (m < 65'sd0) begin
            m = m + 65'sd3;
        end
        return RES_W'(m);
    endfunction

    // Inputs are already in 0..2, so a single conditional subtract of 3
    // normalises both the add case (0..4) and the subtract case (1..5).
    function automatic logic [RES_W-1:0] res_combine(input logic [RES_W-1:0] ra,
                                                     input logic [RES_W-1:0] rb,
                                                     input logic             sub);
        logic [2:0] t;
        if (sub) begin
            t = {1'b0, ra} + 3'd3 - {1'b0, rb};
        end else begin
            t = {1'b0, ra} + {1'b0, rb};
        end
        if (t >= 3'd3) begin
            t = t - 3'd3;
        end
        return RES_W'(t);
    endfunction

endpackage

// File: rtl/addr_signed_pipe_if.sv
// ---------------------------------------------------------------------------
// addr_signed_pipe_if
// Operand and result channels of addr_signed_pipe, both valid/ready.
//   in_valid/in_ready   operand beat handshake
//   in_sub              0: A+B, 1: A-B
//   in_a, in_b          signed operands, WIDTH bits
//   out_valid/out_ready result handshake
//   out_sum             signed full-precision result, WIDTH+1 bits
//   out_err             residue-check mismatch for the beat on out_sum
// Modports: master = operand source / result sink, slave = the adder.
// ---------------------------------------------------------------------------
interface addr_signed_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic             in_sub;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   out_sum;
    logic             out_err;

    modport master (
        output in_valid, in_sub, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_sum, out_err
    );

    modport slave (
        input  in_valid, in_sub, in_a, in_b, out_ready,
        output in_ready, out_valid, out_sum, out_err
    );
endinterface

// File: rtl/addr_pipe_stage.sv
// ---------------------------------------------------------------------------
// addr_pipe_stage
// One carry-chain chunk plus its pipeline register with valid/ready.
// Stage K adds bits [HI:LO] of the running sum vector and the (already
// inverted for subtract) B vector, writes the chunk result back into the sum
// vector and registers it together with the carry-out and B.
// Parameters: W1 = WIDTH+1 vector width, K = stage index, CW = chunk width.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        upstream handshake (in_ready = !valid | out_ready)
//   in_sum, in_b, in_carry   running sum, B operand, carry into this chunk
//   out_valid/out_ready      downstream handshake
//   out_sum, out_b, out_carry registered copies for the next stage
//   load                     this stage captures a beat this cycle
//   sum_next                 value out_sum takes when load is high
// ---------------------------------------------------------------------------
module addr_pipe_stage #(
    parameter int W1 = 9,
    parameter int K  = 0,
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W1-1:0] in_sum,
    input  logic [W1-1:0] in_b,
    input  logic          in_carry,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W1-1:0] out_sum,
    output logic [W1-1:0] out_b,
    output logic          out_carry,
    output logic          load,
    output logic [W1-1:0] sum_next
);

    // When STAGES is close to WIDTH the chunks can run out before the stages
    // do; such trailing stages only delay the beat and pass the carry along.
    localparam int LO_RAW    = K * CW;
    localparam bit HAS_CHUNK = (LO_RAW < W1);
    localparam int LO        = HAS_CHUNK ? LO_RAW : 0;
    localparam int HI        = HAS_CHUNK ? ((LO_RAW + CW - 1 < W1) ? (LO_RAW + CW - 1) : (W1 - 1)) : 0;
    localparam int CHW       = HI - LO + 1;

    logic          valid_q;
    logic [W1-1:0] sum_q;
    logic [W1-1:0] b_q;
    logic          carry_q;
    logic          carry_next;

    if (HAS_CHUNK) begin : g_add
        logic [CHW:0] chunk;

        // Chunk add; the top bit of the extended result is the carry-out
        always_comb begin
            chunk           = {1'b0, in_sum[HI:LO]} + {1'b0, in_b[HI:LO]} + {{CHW{1'b0}}, in_carry};
            sum_next        = in_sum;
            sum_next[HI:LO] = chunk[CHW-1:0];
            carry_next      = chunk[CHW];
        end
    end else begin : g_pass
        always_comb begin
            sum_next   = in_sum;
            carry_next = in_carry;
        end
    end

    // A stage can take a new beat when empty or when its current beat leaves
    assign in_ready = !valid_q || out_ready;
    assign load     = in_valid && in_ready;

    // Valid bit follows the handshake; data only moves on load so a stalled
    // stage keeps its beat untouched
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            sum_q   <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
        end else begin
            if (in_ready) begin
                valid_q <= in_valid;
            end
            if (load) begin
                sum_q   <= sum_next;
                b_q     <= in_b;
                carry_q <= carry_next;
            end
        end
    end

    assign out_valid = valid_q;
    assign out_sum   = sum_q;
    assign out_b     = b_q;
    assign out_carry = carry_q;

endmodule

// File: rtl/addr_signed_pipe.sv
// ---------------------------------------------------------------------------
// addr_signed_pipe
// Pipelined signed adder/subtractor producing a full-precision WIDTH+1 bit
// result. The carry chain is split into STAGES registered chunks; one beat
// per cycle, latency STAGES cycles, results leave in acceptance order.
// Parameters: WIDTH (2..64), STAGES (1..WIDTH)
// Ports:
//   clk   clock, rising edge
//   rst   synchronous active-high reset, discards every in-flight beat
//   bus   addr_signed_pipe_if.slave: in_valid/in_ready/in_sub/in_a/in_b,
//         out_valid/out_ready/out_sum/out_err
// Build option: define ADDR_RESIDUE_CHECK_EN to carry a mod-3 residue of
// each beat through the pipe and flag out_err when the final sum disagrees.
// Without it out_err is tied to 0.
// ---------------------------------------------------------------------------
module addr_signed_pipe
    import addr_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    addr_signed_pipe_if.slave bus
);

    localparam int W1 = WIDTH + 1;
    localparam int CW = chunk_width(WIDTH, STAGES);

    logic [W1-1:0]                a_ext;
    logic [W1-1:0]                b_ext;
    logic [W1-1:0]                b_op;
    logic [STAGES:0][W1-1:0]      sum_chain;
    logic [STAGES:0][W1-1:0]      b_chain;
    logic [STAGES:0]              carry_chain;
    logic [STAGES:0]              valid_chain;
    logic [STAGES:0]              ready_chain;
    logic [STAGES-1:0]            load_vec;
    logic [STAGES-1:0][W1-1:0]    next_vec;

    // Subtract is A + ~B + 1: invert B here and feed in_sub as carry-in
    assign a_ext = {bus.in_a[WIDTH-1], bus.in_a};
    assign b_ext = {bus.in_b[WIDTH-1], bus.in_b};
    assign b_op  = bus.in_sub ? ~b_ext : b_ext;

    assign sum_chain[0]        = a_ext;
    assign b_chain[0]          = b_op;
    assign carry_chain[0]      = bus.in_sub;
    assign valid_chain[0]      = bus.in_valid;
    assign ready_chain[STAGES] = bus.out_ready;
    assign bus.in_ready        = ready_chain[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        addr_pipe_stage #(
            .W1 (W1),
            .K  (k),
            .CW (CW)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (valid_chain[k]),
            .in_ready  (ready_chain[k]),
            .in_sum    (sum_chain[k]),
            .in_b      (b_chain[k]),
            .in_carry  (carry_chain[k]),
            .out_valid (valid_chain[k+1]),
            .out_ready (ready_chain[k+1]),
            .out_sum   (sum_chain[k+1]),
            .out_b     (b_chain[k+1]),
            .out_carry (carry_chain[k+1]),
            .load      (load_vec[k]),
            .sum_next  (next_vec[k])
        );
    end

    assign bus.out_valid = valid_chain[STAGES];
    assign bus.out_sum   = sum_chain[STAGES];

    // The last stage's B copy and carry-out have no consumer; the full sum is
    // already complete in its sum vector
    logic unused_tail;
    logic unused_next;
    assign unused_tail = ^{b_chain[STAGES], carry_chain[STAGES]};
    assign unused_next = ^next_vec;

`ifdef ADDR_RESIDUE_CHECK_EN
    logic signed [64:0] a_wide;
    logic signed [64:0] b_wide;
    logic signed [64:0] next_wide;
    logic [RES_W-1:0]   res_in;
    logic [RES_W-1:0]   res_feed [STAGES];
    logic [RES_W-1:0]   res_q    [STAGES];
    logic               err_q;

    // The residue is taken from the original operands, independent of the
    // inverted B and carry-in used by the adder itself
    assign a_wide    = 65'($signed(a_ext));
    assign b_wide    = 65'($signed(b_ext));
    assign next_wide = 65'($signed(next_vec[STAGES-1]));
    assign res_in    = res_combine(res3(a_wide), res3(b_wide), bus.in_sub);

    // Residue entering each stage: the fresh one for stage 0, otherwise the
    // copy held by the previous stage
    always_comb begin
        res_feed[0] = res_in;
        for (int k = 1; k < STAGES; k++) begin
            res_feed[k] = res_q[k-1];
        end
    end

    // Residues move with the same load strobes as the sum so they stay
    // aligned through stalls; the check is registered alongside out_sum
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                res_q[k] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (load_vec[k]) begin
                    res_q[k] <= res_feed[k];
                end
            end
            if (load_vec[STAGES-1]) begin
                err_q <= (res3(next_wide) != res_feed[STAGES-1]);
            end
        end
    end

    assign bus.out_err = err_q;
`else
    logic unused_load;
    assign unused_load = ^load_vec;
    assign bus.out_err = 1'b0;
`endif

endmodule

// File: tb/tb_addr_signed_pipe.sv
// ---------------------------------------------------------------------------
// tb_addr_signed_pipe
// Directed bench for addr_signed_pipe: WIDTH=8/STAGES=2 instance for the
// hand-computed vectors, backpressure and reset cases, plus a WIDTH=13/
// STAGES=4 instance swept with random operands and random out_ready against
// a behavioural model. With ADDR_RESIDUE_CHECK_EN a stage-0 sum bit is
// forced to show out_err firing.
// ---------------------------------------------------------------------------
module tb_addr_signed_pipe;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    addr_signed_pipe_if #(.WIDTH(8))  bus8  ();
    addr_signed_pipe_if #(.WIDTH(13)) bus13 ();

    addr_signed_pipe #(.WIDTH(8), .STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    addr_signed_pipe #(.WIDTH(13), .STAGES(4)) dut13 (
        .clk (clk),
        .rst (rst),
        .bus (bus13)
    );

    // Streaming table: operands and hand-computed 9-bit results
    logic [7:0] str_a   [8] = '{8'h0A, 8'h64, 8'h9C, 8'hCE, 8'h7F, 8'h80, 8'h01, 8'h40};
    logic [7:0] str_b   [8] = '{8'h14, 8'h9C, 8'h64, 8'hC4, 8'h80, 8'h7F, 8'hFE, 8'h40};
    logic       str_sub [8] = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0};
    logic [8:0] str_exp [8] = '{9'h01E, 9'h0C8, 9'h138, 9'h192, 9'h0FF, 9'h101, 9'h1FF, 9'h080};

    // Random sweep state for the 13-bit instance
    localparam int N13 = 60;
    logic [13:0]        q13 [$];
    int                 sent13;
    int                 got13;
    logic               pend13;
    logic signed [12:0] ra13;
    logic signed [12:0] rb13;
    logic               rsub13;
    logic signed [13:0] ea13;
    logic signed [13:0] eb13;
    logic [13:0]        exp13;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic sub,
                                 input logic [7:0] a, input logic [7:0] b);
        bus8.in_valid = valid;
        bus8.in_sub   = sub;
        bus8.in_a     = a;
        bus8.in_b     = b;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        // Reset both instances
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
        bus8.out_ready  = 1'b1;
        bus13.in_valid  = 1'b0;
        bus13.in_sub    = 1'b0;
        bus13.in_a      = '0;
        bus13.in_b      = '0;
        bus13.out_ready = 1'b1;
        repeat (2) tick();
        checkOutput("reset_out_valid", 64'(bus8.out_valid), 64'd0);
        checkOutput("reset_out_sum",   64'(bus8.out_sum),   64'd0);
        checkOutput("reset_out_err",   64'(bus8.out_err),   64'd0);
        checkOutput("reset13_out_valid", 64'(bus13.out_valid), 64'd0);
        rst = 1'b0;
        tick();
        checkOutput("reset_in_ready", 64'(bus8.in_ready), 64'd1);

        // 127 + 127 = 254, two cycles after the accepting edge
        $display("[TB] max positive add");
        applyStimulus(1'b1, 1'b0, 8'h7F, 8'h7F);
        tick();
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
        checkOutput("t1_not_early", 64'(bus8.out_valid), 64'd0);
        tick();
        checkOutput("t1_valid", 64'(bus8.out_valid), 64'd1);
        checkOutput("t1_sum",   64'(bus8.out_sum),   64'h0FE);
        checkOutput("t1_err",   64'(bus8.out_err),   64'd0);
        tick();
        checkOutput("t1_drained", 64'(bus8.out_valid), 64'd0);

        // -128 + -128, 0 - (-128), -1 + 1 back to back
        $display("[TB] boundary operands");
        applyStimulus(1'b1, 1'b0, 8'h80, 8'h80);
        tick();
        applyStimulus(1'b1, 1'b1, 8'h00, 8'h80);
        tick();
        checkOutput("t2a_valid", 64'(bus8.out_valid), 64'd1);
        checkOutput("t2a_sum",   64'(bus8.out_sum),   64'h100);
        applyStimulus(1'b1, 1'b0, 8'hFF, 8'h01);
        tick();
        checkOutput("t2b_sum", 64'(bus8.out_sum), 64'h080);
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        checkOutput("t2c_valid", 64'(bus8.out_valid), 64'd1);
        checkOutput("t2c_sum",   64'(bus8.out_sum),   64'h000);
        tick();
        checkOutput("t2_drained", 64'(bus8.out_valid), 64'd0);

        // Eight beats back to back, results on consecutive cycles
        $display("[TB] streaming");
        for (int t = 0; t < 10; t++) begin
            if (t < 8) begin
                applyStimulus(1'b1, str_sub[t], str_a[t], str_b[t]);
                checkOutput($sformatf("t3_in_ready_%0d", t), 64'(bus8.in_ready), 64'd1);
            end else begin
                applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
            end
            tick();
            if (t >= 1 && t <= 8) begin
                checkOutput($sformatf("t3_valid_%0d", t - 1), 64'(bus8.out_valid), 64'd1);
                checkOutput($sformatf("t3_sum_%0d", t - 1),   64'(bus8.out_sum),   64'(str_exp[t-1]));
            end else if (t == 9) begin
                checkOutput("t3_drained", 64'(bus8.out_valid), 64'd0);
            end
        end

        // Backpressure: two beats fill the pipe, the third waits
        $display("[TB] backpressure");
        bus8.out_ready = 1'b0;
        applyStimulus(1'b1, 1'b0, 8'h7F, 8'h7F);
        checkOutput("t4_ready_beat0", 64'(bus8.in_ready), 64'd1);
        tick();
        applyStimulus(1'b1, 1'b0, 8'h80, 8'h80);
        checkOutput("t4_ready_beat1", 64'(bus8.in_ready), 64'd1);
        tick();
        applyStimulus(1'b1, 1'b0, 8'h05, 8'h03);
        checkOutput("t4_ready_drop", 64'(bus8.in_ready), 64'd0);
        checkOutput("t4_head_valid", 64'(bus8.out_valid), 64'd1);
        checkOutput("t4_head_sum",   64'(bus8.out_sum),   64'h0FE);
        tick();
        checkOutput("t4_ready_held", 64'(bus8.in_ready), 64'd0);
        checkOutput("t4_sum_held",   64'(bus8.out_sum),  64'h0FE);
        tick();
        checkOutput("t4_sum_held2",  64'(bus8.out_sum),  64'h0FE);
        bus8.out_ready = 1'b1;
        #1;
        checkOutput("t4_ready_release", 64'(bus8.in_ready), 64'd1);
        tick();
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
        checkOutput("t4_res1_valid", 64'(bus8.out_valid), 64'd1);
        checkOutput("t4_res1_sum",   64'(bus8.out_sum),   64'h100);
        tick();
        checkOutput("t4_res2_valid", 64'(bus8.out_valid), 64'd1);
        checkOutput("t4_res2_sum",   64'(bus8.out_sum),   64'h008);
        tick();
        checkOutput("t4_drained", 64'(bus8.out_valid), 64'd0);

        // Reset with two beats in flight
        $display("[TB] reset mid-flight");
        applyStimulus(1'b1, 1'b0, 8'd20, 8'd22);
        tick();
        applyStimulus(1'b1, 1'b0, 8'd1, 8'd1);
        tick();
        checkOutput("t5_inflight_sum", 64'(bus8.out_sum), 64'h02A);
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
        rst = 1'b1;
        tick();
        checkOutput("t5_flush_valid", 64'(bus8.out_valid), 64'd0);
        rst = 1'b0;
        tick();
        checkOutput("t5_post_valid", 64'(bus8.out_valid), 64'd0);
        checkOutput("t5_post_ready", 64'(bus8.in_ready),  64'd1);
        applyStimulus(1'b1, 1'b0, 8'd3, 8'd4);
        tick();
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
        checkOutput("t5_no_stale", 64'(bus8.out_valid), 64'd0);
        tick();
        checkOutput("t5_new_valid", 64'(bus8.out_valid), 64'd1);
        checkOutput("t5_new_sum",   64'(bus8.out_sum),   64'h007);
        tick();
        checkOutput("t5_drained", 64'(bus8.out_valid), 64'd0);

`ifdef ADDR_RESIDUE_CHECK_EN
        // 5 + 3 with the stage-0 sum bit 0 flipped: 9 instead of 8
        $display("[TB] residue fault");
        applyStimulus(1'b1, 1'b0, 8'd5, 8'd3);
        tick();
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
        force dut.g_stage[0].u_stage.sum_q = 9'h009;
        tick();
        release dut.g_stage[0].u_stage.sum_q;
        checkOutput("t6_fault_sum", 64'(bus8.out_sum), 64'h009);
        checkOutput("t6_fault_err", 64'(bus8.out_err), 64'd1);
        tick();
`endif

        // Random sweep on the 13-bit, 4-stage instance with random backpressure
        $display("[TB] random sweep 13x4");
        sent13 = 0;
        got13  = 0;
        pend13 = 1'b0;
        rsub13 = 1'b0;
        ra13   = '0;
        rb13   = '0;
        for (int cyc = 0; cyc < 3000 && got13 < N13; cyc++) begin
            bus13.out_ready = ($urandom_range(0, 3) != 0);
            if (!pend13 && sent13 < N13) begin
                ra13   = 13'($urandom);
                rb13   = 13'($urandom);
                rsub13 = 1'($urandom);
                pend13 = 1'b1;
            end
            bus13.in_valid = pend13;
            bus13.in_sub   = rsub13;
            bus13.in_a     = ra13;
            bus13.in_b     = rb13;
            #1;
            if (bus13.out_valid && bus13.out_ready) begin
                exp13 = (q13.size() > 0) ? q13.pop_front() : 14'bx;
                checkOutput($sformatf("sweep_sum_%0d", got13), 64'(bus13.out_sum), 64'(exp13));
                checkOutput($sformatf("sweep_err_%0d", got13), 64'(bus13.out_err), 64'd0);
                got13++;
            end
            if (bus13.in_valid && bus13.in_ready) begin
                ea13 = 14'(ra13);
                eb13 = 14'(rb13);
                q13.push_back(rsub13 ? 14'(ea13 - eb13) : 14'(ea13 + eb13));
                pend13 = 1'b0;
                sent13++;
            end
            tick();
        end
        checkOutput("sweep_count",   64'(got13),      64'(N13));
        checkOutput("sweep_leftover", 64'(q13.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
